fb_read_arbiter: RTL and testbench

Shares the single frame-buffer BRAM read port among several pixel readers: the downsampler, the finder-pattern locator and the display scan-out. Accepts one read per cycle from a round-robin-selected requester and drives the BRAM address. It tracks each outstanding read through the fixed BRAM latency and returns the pixel to the requester that issued it. It sits between the frame buffer and all pixel readers, so none of them drives the BRAM address directly.

---
 rtl/fb_pkg.sv | 24 ++
 rtl/fb_read_arbiter_rr_grant.sv | 71 +++++++
 rtl/fb_read_arbiter.sv | 119 +++++++++++
 tb/tb_fb_read_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: shared definitions for the frame-buffer read path.
//   FB_ADDR_W      frame-buffer address width
//   FB_WIDTH       frame width in pixels
//   FB_IDX_W       width of a requester index / response tag
//   fb_req_e       requester identities (index 0 is display scan-out)
//   fb_tag_stage_t one stage of the in-flight read tracker (valid + requester index)
package fb_pkg;

  localparam int FB_ADDR_W = 20;
  localparam int FB_WIDTH  = 480;
  localparam int FB_IDX_W  = 2;

  typedef enum logic [FB_IDX_W-1:0] {
    REQ_DISPLAY    = 2'd0,
    REQ_FINDER     = 2'd1,
    REQ_DOWNSAMPLE = 2'd2
  } fb_req_e;

  typedef struct packed {
    logic                valid;
    logic [FB_IDX_W-1:0] idx;
  } fb_tag_stage_t;

endpackage

// File: rtl/fb_read_arbiter_rr_grant.sv
// rr_grant: purely combinational round-robin grant for the frame-buffer read port.
// Build option: FB_ARB_DISPLAY_PRIORITY_EN -- when defined, requester 0 (display)
// wins whenever it is valid and not held; the pointer is then left untouched so
// the other requesters keep their round-robin position.
// Ports:
//   valid     per-requester request vector
//   hold      suppresses every grant
//   rr_ptr    index where the round-robin search starts
//   grant     one-hot grant (all zero when nothing is granted)
//   grant_idx binary index of the granted requester
//   next_ptr  pointer value to load on the next edge (equals rr_ptr when no advance)
module rr_grant
  import fb_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]  valid,
  input  logic                hold,
  input  logic [FB_IDX_W-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]  grant,
  output logic [FB_IDX_W-1:0] grant_idx,
  output logic [FB_IDX_W-1:0] next_ptr
);

  logic pri_hit_s;
  logic rr_hit_s;
  logic take_s;
  int   start_s;
  int   dist_s;
  int   best_dist_s;
  int   best_idx_s;

  // Display override: only active in the priority build
  always_comb begin
`ifdef FB_ARB_DISPLAY_PRIORITY_EN
    pri_hit_s = ~hold & valid[REQ_DISPLAY];
`else
    pri_hit_s = 1'b0;
`endif
  end

  // Round-robin search: the valid requester at the smallest wrapped distance
  // from rr_ptr wins. An out-of-range pointer is treated as 0 so a corrupted
  // pointer can never starve anyone.
  always_comb begin
    start_s     = (int'(rr_ptr) < NUM_REQ) ? int'(rr_ptr) : 0;
    dist_s      = 0;
    take_s      = 1'b0;
    best_dist_s = NUM_REQ;
    best_idx_s  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      dist_s      = (i >= start_s) ? (i - start_s) : (i + NUM_REQ - start_s);
      take_s      = valid[i] && (dist_s < best_dist_s);
      best_idx_s  = take_s ? i : best_idx_s;
      best_dist_s = take_s ? dist_s : best_dist_s;
    end
    rr_hit_s = ~hold & ~pri_hit_s & (best_dist_s < NUM_REQ);
  end

  // Grant vector and pointer update; a display-priority grant leaves rr_ptr alone
  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = (pri_hit_s && (i == 0)) || (rr_hit_s && (i == best_idx_s));
    end
    grant_idx = rr_hit_s ? FB_IDX_W'(best_idx_s) : '0;
    next_ptr  = rr_hit_s ? ((best_idx_s == NUM_REQ - 1) ? '0 : FB_IDX_W'(best_idx_s + 1))
                         : rr_ptr;
  end

endmodule

// File: rtl/fb_read_arbiter.sv
// fb_read_arbiter: shares the single frame-buffer BRAM read port among the pixel
// readers (0 = display scan-out, 1 = finder, 2 = downsampler). One read is accepted
// per cycle, the address is registered onto the BRAM port, and a tag pipeline
// follows each read through the fixed BRAM latency so the pixel is returned to
// the requester that issued it. Responses have no backpressure.
// Build option: FB_ARB_DISPLAY_PRIORITY_EN (see rr_grant) gives the display
// requester absolute priority; undefined means pure round robin.
// Parameters: NUM_REQ (<= 2**FB_IDX_W), ADDR_W, READ_LATENCY (1..4).
// Ports:
//   clk_in, rst_n_in  clock, asynchronous active-low reset
//   req_valid_in      per-requester read request
//   req_addr_in       packed addresses, requester i at slice i
//   req_ready_out     one-hot grant (combinational)
//   rsp_valid_out     one-hot response strobe
//   rsp_pixel_out     returned pixel (0 when no response)
//   hold_in           blocks new grants; in-flight reads still complete
//   bram_addr_out     registered BRAM read address
//   bram_en_out       registered BRAM read enable
//   bram_dout_in      BRAM read data
module fb_read_arbiter
  import fb_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int ADDR_W       = FB_ADDR_W,
  parameter int READ_LATENCY = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic [NUM_REQ-1:0]        req_valid_in,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_in,
  output logic [NUM_REQ-1:0]        req_ready_out,
  output logic [NUM_REQ-1:0]        rsp_valid_out,
  output logic                      rsp_pixel_out,
  input  logic                      hold_in,
  output logic [ADDR_W-1:0]         bram_addr_out,
  output logic                      bram_en_out,
  input  logic                      bram_dout_in
);

  logic [NUM_REQ-1:0]  grant_s;
  logic [FB_IDX_W-1:0] grant_idx_s;
  logic [FB_IDX_W-1:0] next_ptr_s;
  logic                accept_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  fb_tag_stage_t       last_tag_s;

  logic [FB_IDX_W-1:0] rr_ptr_r;
  logic                bram_en_r;
  logic [ADDR_W-1:0]   bram_addr_r;
  logic [FB_IDX_W-1:0] issue_idx_r;
  fb_tag_stage_t       tag_pipe_r [READ_LATENCY];

  rr_grant #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_grant (
    .valid     (req_valid_in),
    .hold      (hold_in),
    .rr_ptr    (rr_ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .next_ptr  (next_ptr_s)
  );

  // A grant is only ever given to a valid requester, so any grant is an accept
  assign accept_s      = |grant_s;
  assign req_ready_out = grant_s;

  // Address mux: AND-OR over the one-hot grant
  always_comb begin
    sel_addr_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_addr_s = sel_addr_s | (req_addr_in[i*ADDR_W +: ADDR_W] & {ADDR_W{grant_s[i]}});
    end
  end

  // Issue stage: pointer, BRAM address/enable and the tag of the read being issued
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rr_ptr_r    <= '0;
      bram_en_r   <= 1'b0;
      bram_addr_r <= '0;
      issue_idx_r <= '0;
    end else begin
      rr_ptr_r    <= next_ptr_s;
      bram_en_r   <= accept_s;
      bram_addr_r <= accept_s ? sel_addr_s : bram_addr_r;
      issue_idx_r <= accept_s ? grant_idx_s : issue_idx_r;
    end
  end

  // Tag pipeline: fed from the issue stage, so the last stage lines up with
  // bram_dout_in READ_LATENCY cycles after the address was presented
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        tag_pipe_r[k] <= '0;
      end
    end else begin
      tag_pipe_r[0] <= fb_tag_stage_t'{valid: bram_en_r, idx: issue_idx_r};
      for (int k = 1; k < READ_LATENCY; k++) begin
        tag_pipe_r[k] <= tag_pipe_r[k-1];
      end
    end
  end

  assign last_tag_s    = tag_pipe_r[READ_LATENCY-1];
  assign bram_en_out   = bram_en_r;
  assign bram_addr_out = bram_addr_r;

  // Response decode: pixel is passed through only while a tagged read lands
  always_comb begin
    rsp_valid_out = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid_out[i] = last_tag_s.valid && (last_tag_s.idx == FB_IDX_W'(i));
    end
    rsp_pixel_out = last_tag_s.valid & bram_dout_in;
  end

endmodule

// File: tb/tb_fb_read_arbiter.sv
// Self-checking bench for fb_read_arbiter. Two instances (READ_LATENCY 2 and 4)
// share the request stimulus; each has its own BRAM model. A transaction-level
// reference model (round-robin pointer + queue of expected responses with due
// cycles) predicts grants, BRAM port activity and returned pixels.
module tb_fb_read_arbiter;

  localparam int N  = 3;
  localparam int AW = 20;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic            hold = 1'b0;

  logic [N-1:0]    ready2, ready4, rsp_v2, rsp_v4;
  logic            pix2, pix4, ben2, ben4, dout2, dout4;
  logic [AW-1:0]   baddr2, baddr4;

  always #5 clk = ~clk;

  fb_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .READ_LATENCY(2)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .req_valid_in(req_valid), .req_addr_in(req_addr),
    .req_ready_out(ready2), .rsp_valid_out(rsp_v2), .rsp_pixel_out(pix2), .hold_in(hold),
    .bram_addr_out(baddr2), .bram_en_out(ben2), .bram_dout_in(dout2));

  fb_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .READ_LATENCY(4)) dut_l4 (
    .clk_in(clk), .rst_n_in(rst_n), .req_valid_in(req_valid), .req_addr_in(req_addr),
    .req_ready_out(ready4), .rsp_valid_out(rsp_v4), .rsp_pixel_out(pix4), .hold_in(hold),
    .bram_addr_out(baddr4), .bram_en_out(ben4), .bram_dout_in(dout4));

  // Frame-buffer content: a fixed pseudo-random bit per address
  function automatic logic pix_of(input logic [AW-1:0] a);
    return ~^(a & 20'hA5C3B);
  endfunction

  // BRAM models: data appears READ_LATENCY cycles after the registered address;
  // when the read was not enabled the output is noise
  logic [AW-1:0] pa2 [2];
  logic          pe2 [2];
  logic [AW-1:0] pa4 [4];
  logic          pe4 [4];
  logic          noise;

  always @(posedge clk) begin
    noise  <= 1'($urandom);
    pa2[0] <= baddr2;
    pe2[0] <= ben2;
    pa2[1] <= pa2[0];
    pe2[1] <= pe2[0];
    for (int k = 1; k < 4; k++) begin
      pa4[k] <= pa4[k-1];
      pe4[k] <= pe4[k-1];
    end
    pa4[0] <= baddr4;
    pe4[0] <= ben4;
  end

  assign dout2 = (pe2[1] === 1'b1) ? pix_of(pa2[1]) : noise;
  assign dout4 = (pe4[3] === 1'b1) ? pix_of(pa4[3]) : noise;

  // Reference model state
  typedef struct {
    int   due;
    int   req;
    logic pix;
  } rsp_t;

  rsp_t          q2[$];
  rsp_t          q4[$];
  int            glog[$];
  int            ptr = 0;
  int            cyc = 0;
  logic          exp_en = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  int            checks = 0;
  int            failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  // Which requester should win this cycle, from the arbitration rules
  function automatic int model_grant(input logic [N-1:0] v, input logic h);
    int i;
    if (h) return -1;
`ifdef FB_ARB_DISPLAY_PRIORITY_EN
    if (v[0]) return 0;
`endif
    for (int off = 0; off < N; off++) begin
      i = (ptr + off) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N*AW-1:0] rand_addrs();
    return (N*AW)'({$urandom(), $urandom()});
  endfunction

  // One clock cycle: drive, check every output against the model, advance the model
  task automatic step(input logic [N-1:0] v, input logic [N*AW-1:0] a, input logic h);
    int            g;
    logic [N-1:0]  er;
    logic [N-1:0]  ev;
    logic          ep;
    logic [AW-1:0] ga;
    @(posedge clk);
    #1;
    req_valid = v;
    req_addr  = a;
    hold      = h;
    @(negedge clk);
    g  = model_grant(v, h);
    er = (g >= 0) ? N'(1 << g) : '0;
    check_eq("ready_l2", 32'(ready2), 32'(er));
    check_eq("ready_l4", 32'(ready4), 32'(er));
    check_eq("bram_en_l2", 32'(ben2), 32'(exp_en));
    check_eq("bram_en_l4", 32'(ben4), 32'(exp_en));
    check_eq("bram_addr_l2", 32'(baddr2), 32'(exp_addr));
    check_eq("bram_addr_l4", 32'(baddr4), 32'(exp_addr));

    ev = '0;
    ep = 1'b0;
    if (q2.size() > 0 && q2[0].due == cyc) begin
      ev = N'(1 << q2[0].req);
      ep = q2[0].pix;
      void'(q2.pop_front());
    end
    check_eq("rsp_valid_l2", 32'(rsp_v2), 32'(ev));
    check_eq("rsp_pixel_l2", 32'(pix2), 32'(ep));

    ev = '0;
    ep = 1'b0;
    if (q4.size() > 0 && q4[0].due == cyc) begin
      ev = N'(1 << q4[0].req);
      ep = q4[0].pix;
      void'(q4.pop_front());
    end
    check_eq("rsp_valid_l4", 32'(rsp_v4), 32'(ev));
    check_eq("rsp_pixel_l4", 32'(pix4), 32'(ep));

    exp_en = (g >= 0);
    if (g >= 0) begin
      ga       = a[g*AW +: AW];
      exp_addr = ga;
      q2.push_back('{due: cyc + 3, req: g, pix: pix_of(ga)});
      q4.push_back('{due: cyc + 5, req: g, pix: pix_of(ga)});
      glog.push_back(g);
`ifdef FB_ARB_DISPLAY_PRIORITY_EN
      if (g != 0) ptr = (g + 1) % N;
`else
      ptr = (g + 1) % N;
`endif
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, rand_addrs(), 1'b0);
  endtask

  // One-cycle reset pulse; outputs must clear immediately and the model restarts
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = '0;
    hold      = 1'b0;
    #1;
    check_eq("rst_ready", 32'({ready2, ready4}), 32'd0);
    check_eq("rst_rsp_valid", 32'({rsp_v2, rsp_v4}), 32'd0);
    check_eq("rst_rsp_pixel", 32'({pix2, pix4}), 32'd0);
    check_eq("rst_bram_en", 32'({ben2, ben4}), 32'd0);
    check_eq("rst_bram_addr_l2", 32'(baddr2), 32'd0);
    check_eq("rst_bram_addr_l4", 32'(baddr4), 32'd0);
    ptr = 0;
    q2.delete();
    q4.delete();
    exp_en   = 1'b0;
    exp_addr = '0;
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N*AW-1:0] a;
    int exp_c[6];
    int exp_p[4];

    // Single request from requester 2
    do_reset();
    a = rand_addrs();
    a[2*AW +: AW] = 20'h00F3A;
    step(3'b100, a, 1'b0);
    idle(6);

    // Contention from rr_ptr = 0
    do_reset();
    glog.delete();
    for (int k = 0; k < 6; k++) step(3'b111, rand_addrs(), 1'b0);
`ifdef FB_ARB_DISPLAY_PRIORITY_EN
    exp_c = '{0, 0, 0, 0, 0, 0};
`else
    exp_c = '{0, 1, 2, 0, 1, 2};
`endif
    check_eq("order_len", 32'(glog.size()), 32'd6);
    for (int k = 0; k < 6 && k < glog.size(); k++)
      check_eq($sformatf("order%0d", k), 32'(glog[k]), 32'(exp_c[k]));
    idle(6);

    // Hold with two reads in flight, then release
    do_reset();
    step(3'b011, rand_addrs(), 1'b0);
    step(3'b011, rand_addrs(), 1'b0);
    for (int k = 0; k < 4; k++) step(3'b111, rand_addrs(), 1'b1);
    step(3'b111, rand_addrs(), 1'b0);
    idle(6);

    // Reset one cycle after an accept: nothing may come back
    do_reset();
    step(3'b010, rand_addrs(), 1'b0);
    do_reset();
    idle(5);

    // Requesters 0 and 2 continuously
    do_reset();
    glog.delete();
    for (int k = 0; k < 4; k++) step(3'b101, rand_addrs(), 1'b0);
`ifdef FB_ARB_DISPLAY_PRIORITY_EN
    exp_p = '{0, 0, 0, 0};
`else
    exp_p = '{0, 2, 0, 2};
`endif
    check_eq("pri_len", 32'(glog.size()), 32'd4);
    for (int k = 0; k < 4 && k < glog.size(); k++)
      check_eq($sformatf("pri%0d", k), 32'(glog[k]), 32'(exp_p[k]));
    idle(6);

    // Random traffic with occasional hold and reset
    do_reset();
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      step(N'($urandom), rand_addrs(), ($urandom_range(0, 7) == 0));
    end
    idle(6);
    check_eq("drain_l2", 32'(q2.size()), 32'd0);
    check_eq("drain_l4", 32'(q4.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
